// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and the memory arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SERVE_I = 2'b01,
    SERVE_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/mux2.sv
// Parameterised two-input multiplexer; sel=1 selects b.
module mux2 #(
  parameter int width = 16
) (
  input  logic             sel,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] f
);

  assign f = sel ? b : a;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one physical memory port between icache and dcache.
// state   | meaning
// IDLE    | no pmem strobe; arbitrate pending requests
// SERVE_I | icache fill in flight, held until pmem_resp
// SERVE_D | dcache fill/writeback in flight, held until pmem_resp
module mem_arbiter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_read,
  input  lc3b_word i_address,
  output logic     i_resp,
  output lc3b_line i_rdata,
  input  logic     d_read,
  input  logic     d_write,
  input  lc3b_word d_address,
  input  lc3b_line d_wdata,
  output logic     d_resp,
  output lc3b_line d_rdata,
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output lc3b_line pmem_wdata,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);

  arb_state_t state, state_next;
  grant_t     last_grant;
  logic       i_req, d_req, sel_d;

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  assign sel_d = (state == SERVE_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == SERVE_I)
        last_grant <= GRANT_I;
      else if (state == IDLE && state_next == SERVE_D)
        last_grant <= GRANT_D;
    end
  end

  always_comb begin
    state_next = state;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req)
          state_next = (last_grant == GRANT_I) ? SERVE_D : SERVE_I;
        else if (i_req)
          state_next = SERVE_I;
        else if (d_req)
          state_next = SERVE_D;
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        i_resp    = pmem_resp;
        if (pmem_resp) state_next = IDLE;
      end
      SERVE_D: begin
        // A simultaneous read+write is a writeback.
        pmem_read  = d_read & ~d_write;
        pmem_write = d_write;
        d_resp     = pmem_resp;
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mux2 #(.width(16)) addr_mux (
    .sel (sel_d),
    .a   (i_address),
    .b   (d_address),
    .f   (pmem_address)
  );

  mux2 #(.width(128)) wdata_mux (
    .sel (sel_d),
    .a   ('0),
    .b   (d_wdata),
    .f   (pmem_wdata)
  );

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a behavioural memory, issue/response monitors.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read, d_read, d_write;
  logic [15:0]  i_address, d_address;
  logic [127:0] d_wdata;
  logic         i_resp, d_resp;
  logic [127:0] i_rdata, d_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } issue_t;

  typedef struct {
    logic         ir;
    logic         dr;
    logic [127:0] data;
  } resp_t;

  issue_t issue_q[$];
  resp_t  resp_q[$];

  localparam logic [127:0] DATA_A5 = {16{8'hA5}};
  localparam logic [127:0] WDATA   = {4{32'hDEADBEEF}};

  logic [127:0] mem_data;
  bit           mem_en = 1'b1;
  int           mem_cnt = 0;

  mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_resp       (i_resp),
    .i_rdata      (i_rdata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_resp       (d_resp),
    .d_rdata      (d_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  // Memory model: responds on the third cycle a strobe is seen.
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mem_cnt   = 0;
      pmem_resp = 1'b0;
    end else if (mem_en) begin
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        mem_cnt   = 0;
      end else if (pmem_read | pmem_write) begin
        mem_cnt++;
        if (mem_cnt == 3) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_data;
        end
      end
    end
  end

  logic prev_act = 1'b0;
  always @(negedge clk) begin
    logic   act;
    issue_t e;
    act = pmem_read | pmem_write;
    if (act && !prev_act) begin
      checks++;
      if (issue_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected rd=%0b wr=%0b addr=%h", pmem_read, pmem_write, pmem_address);
      end else begin
        e = issue_q.pop_front();
        if (pmem_read !== e.rd || pmem_write !== e.wr || pmem_address !== e.addr ||
            (e.wr && pmem_wdata !== e.wdata)) begin
          errors++;
          $display("FAIL issue got rd=%0b wr=%0b addr=%h wdata=%h, expected rd=%0b wr=%0b addr=%h wdata=%h",
                   pmem_read, pmem_write, pmem_address, pmem_wdata, e.rd, e.wr, e.addr, e.wdata);
        end
      end
    end
    prev_act = act;
  end

  always @(negedge clk) begin
    resp_t r;
    if (i_resp || d_resp) begin
      checks++;
      if (resp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected i_resp=%0b d_resp=%0b", i_resp, d_resp);
      end else begin
        r = resp_q.pop_front();
        if (i_resp !== r.ir || d_resp !== r.dr || i_rdata !== r.data || d_rdata !== r.data) begin
          errors++;
          $display("FAIL resp got i=%0b d=%0b idata=%h ddata=%h, expected i=%0b d=%0b data=%h",
                   i_resp, d_resp, i_rdata, d_rdata, r.ir, r.dr, r.data);
        end
      end
    end
  end

  function automatic void exp_issue(input logic rd, input logic wr, input logic [15:0] addr,
                                    input logic [127:0] wdata);
    issue_q.push_back(issue_t'{rd, wr, addr, wdata});
  endfunction

  function automatic void exp_resp(input logic ir, input logic dr, input logic [127:0] data);
    resp_q.push_back(resp_t'{ir, dr, data});
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Runs until n responses; without hold each requester drops the cycle after its resp.
  task automatic wait_resps(input int n, input bit hold);
    int seen = 0;
    int cyc  = 0;
    bit saw_i, saw_d;
    while (seen < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      saw_i = i_resp;
      saw_d = d_resp;
      if (saw_i) seen++;
      if (saw_d) seen++;
      @(posedge clk);
      #1;
      if (!hold) begin
        if (saw_i) i_read = 1'b0;
        if (saw_d) begin
          d_read  = 1'b0;
          d_write = 1'b0;
        end
      end
    end
    if (hold) begin
      i_read  = 1'b0;
      d_read  = 1'b0;
      d_write = 1'b0;
    end
    checks++;
    if (seen < n) begin
      errors++;
      $display("FAIL resp_timeout seen=%0d expected=%0d", seen, n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_strobes", {126'd0, pmem_read, pmem_write}, '0);
    chk("reset_resps", {126'd0, i_resp, d_resp}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic tie_read(input logic [15:0] ia, input logic [15:0] da, input logic [127:0] data);
    mem_data  = data;
    i_address = ia;
    d_address = da;
    i_read    = 1'b1;
    d_read    = 1'b1;
    exp_issue(1'b1, 1'b0, da, '0);
    exp_issue(1'b1, 1'b0, ia, '0);
    exp_resp(1'b0, 1'b1, data);
    exp_resp(1'b1, 1'b0, data);
    wait_resps(2, 1'b0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    i_read     = 1'b0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    i_address  = '0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    mem_data   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {126'd0, pmem_read, pmem_write}, '0);
    chk("reset_resps", {126'd0, i_resp, d_resp}, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lone icache fill, strobe one cycle after the request is first seen
    mem_data  = DATA_A5;
    i_address = 16'h1230;
    i_read    = 1'b1;
    exp_issue(1'b1, 1'b0, 16'h1230, '0);
    exp_resp(1'b1, 1'b0, DATA_A5);
    @(negedge clk);
    chk("idle_no_strobe", {127'd0, pmem_read}, 128'd0);
    @(negedge clk);
    chk("latency_strobe", {127'd0, pmem_read}, 128'd1);
    chk("latency_addr", {112'd0, pmem_address}, {112'd0, 16'h1230});
    wait_resps(1, 1'b0);

    // Tie right after reset goes to D
    pulse_reset();
    tie_read(16'h1100, 16'h2200, {8{16'h3C3C}});

    // Round robin with both requests held: D, I, D, I
    mem_data  = {4{32'h0F0F1234}};
    i_address = 16'h1300;
    d_address = 16'h2300;
    d_wdata   = WDATA;
    i_read    = 1'b1;
    d_write   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_issue(1'b0, 1'b1, 16'h2300, WDATA);
      exp_issue(1'b1, 1'b0, 16'h1300, '0);
      exp_resp(1'b0, 1'b1, mem_data);
      exp_resp(1'b1, 1'b0, mem_data);
    end
    wait_resps(4, 1'b1);

    // Read and write together is a writeback
    mem_data  = {8{16'h7777}};
    d_address = 16'h4000;
    d_read    = 1'b1;
    d_write   = 1'b1;
    exp_issue(1'b0, 1'b1, 16'h4000, WDATA);
    exp_resp(1'b0, 1'b1, mem_data);
    wait_resps(1, 1'b0);

    // last_grant is D here; reset must restore I so the tie goes to D
    pulse_reset();
    tie_read(16'h1500, 16'h2500, {8{16'h5A5A}});

    // Reset in the middle of an icache fill
    mem_data  = {8{16'hBEEF}};
    i_address = 16'h5550;
    i_read    = 1'b1;
    exp_issue(1'b1, 1'b0, 16'h5550, '0);
    @(negedge clk);
    @(negedge clk);
    chk("midfill_strobe", {127'd0, pmem_read}, 128'd1);
    rst_n  = 1'b0;
    i_read = 1'b0;
    #1;
    chk("midfill_async_drop", {126'd0, pmem_read, pmem_write}, '0);
    chk("midfill_no_resp", {126'd0, i_resp, d_resp}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tie_read(16'h1600, 16'h2600, {8{16'h6161}});

    // Spurious pmem_resp while idle
    mem_en     = 1'b0;
    pmem_rdata = {8{16'hFACE}};
    pmem_resp  = 1'b1;
    @(negedge clk);
    chk("spurious_no_resp", {126'd0, i_resp, d_resp}, '0);
    chk("spurious_no_strobe", {126'd0, pmem_read, pmem_write}, '0);
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    @(negedge clk);
    chk("spurious_stays_idle", {126'd0, pmem_read, pmem_write}, '0);
    @(posedge clk);
    #1;
    mem_en = 1'b1;

    mem_data  = {8{16'h0606}};
    d_address = 16'h6060;
    d_read    = 1'b1;
    exp_issue(1'b1, 1'b0, 16'h6060, '0);
    exp_resp(1'b0, 1'b1, mem_data);
    wait_resps(1, 1'b0);

    chk("scoreboard_drained", {96'd0, 16'(issue_q.size()), 16'(resp_q.size())}, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
